// File: rtl/led_blink_arbiter_if.sv
// Requester-side bundle of the LED blink arbiter: request/code in, ack/status/led out.
interface led_blink_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int CODE_WIDTH = 4
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*CODE_WIDTH-1:0] code;
  logic [NUM_REQ-1:0]            ack;
  logic                          busy;
  logic [GID_W-1:0]              grant_id;
  logic                          led;

  // status sources drive requests and watch completion
  modport master (output req, code, input ack, busy, grant_id, led);
  // the arbiter consumes requests and drives the pin and status
  modport slave  (input req, code, output ack, busy, grant_id, led);
endinterface

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter sharing one LED between NUM_REQ requesters; the granted
// requester's blink code (N pulses then a gap) is played with tick-exact phases.
module led_blink_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int CODE_WIDTH = 4,
  parameter int TICK_DIV   = 1000000,
  parameter int ON_TICKS   = 4,
  parameter int OFF_TICKS  = 4,
  parameter int GAP_TICKS  = 16,
  parameter int HEARTBEAT  = 1,
  parameter int HB_TICKS   = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  led_blink_arbiter_if.slave   bus
);
  localparam int GID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_MAX = (ON_TICKS > OFF_TICKS)
                          ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                          : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int HB_W   = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ON, S_OFF, S_GAP, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic [PRE_W-1:0]                presc_q, presc_d;
  logic [PH_W-1:0]                 phase_q, phase_d;
  logic [CODE_WIDTH-1:0]           pulse_q, pulse_d;
  logic [CODE_WIDTH-1:0]           code_q, code_d;
  logic [GID_W-1:0]                gid_q, gid_d;
  logic [GID_W-1:0]                rr_q, rr_d;
  logic [HB_W-1:0]                 hb_cnt_q, hb_cnt_d;
  logic                            hb_led_q, hb_led_d;
  logic                            led_q, led_d;
  logic                            busy_q, busy_d;
  logic [NUM_REQ-1:0]              ack_q, ack_d;

  logic [NUM_REQ-1:0][CODE_WIDTH-1:0] codes;
  logic                               tick;
  logic                               pick_vld;
  logic [GID_W-1:0]                   pick_id;
  logic [CODE_WIDTH-1:0]              pulse_nx;

  assign codes    = bus.code;
  assign tick     = (presc_q == PRE_W'(TICK_DIV - 1));
  assign pulse_nx = pulse_q + 1'b1;

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.ack      = ack_q;
  assign bus.grant_id = gid_q;

  // Round-robin pick: first set request at or above rr_q, wrapping; scanning the
  // offsets downward lets the smallest offset win.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(rr_q) + i) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_id  = GID_W'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      phase_q  <= '0;
      pulse_q  <= '0;
      code_q   <= '0;
      gid_q    <= '0;
      rr_q     <= '0;
      hb_cnt_q <= '0;
      hb_led_q <= 1'b0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      pulse_q  <= pulse_d;
      code_q   <= code_d;
      gid_q    <= gid_d;
      rr_q     <= rr_d;
      hb_cnt_q <= hb_cnt_d;
      hb_led_q <= hb_led_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
    end
  end

  // Next state: phase timing in ticks, pulse counting, grant latching, heartbeat.
  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + 1'b1;
    phase_d  = phase_q;
    pulse_d  = pulse_q;
    code_d   = code_q;
    gid_d    = gid_q;
    rr_d     = rr_q;
    hb_cnt_d = hb_cnt_q;
    hb_led_d = hb_led_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          // restart the tick grid so the first phase is exactly timed
          gid_d    = pick_id;
          code_d   = codes[pick_id];
          pulse_d  = '0;
          presc_d  = '0;
          phase_d  = '0;
          hb_cnt_d = '0;
          hb_led_d = 1'b0;
          state_d  = (codes[pick_id] == '0) ? S_GAP : S_ON;
        end else if (tick) begin
          if (hb_cnt_q == HB_W'(HB_TICKS - 1)) begin
            hb_cnt_d = '0;
            hb_led_d = ~hb_led_q;
          end else begin
            hb_cnt_d = hb_cnt_q + 1'b1;
          end
        end
      end
      S_ON: begin
        if (tick) begin
          if (phase_q == PH_W'(ON_TICKS - 1)) begin
            phase_d = '0;
            pulse_d = pulse_nx;
            state_d = (pulse_nx == code_q) ? S_GAP : S_OFF;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      S_OFF: begin
        if (tick) begin
          if (phase_q == PH_W'(OFF_TICKS - 1)) begin
            phase_d = '0;
            state_d = S_ON;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (phase_q == PH_W'(GAP_TICKS - 1)) begin
            phase_d = '0;
            state_d = S_DONE;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // the requester just served drops to lowest priority
        rr_d    = (gid_q == GID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs derived from the upcoming state so that they are registered.
  always_comb begin
    led_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    ack_d  = '0;
    case (state_d)
      S_ON:    led_d = 1'b1;
      S_IDLE:  led_d = (HEARTBEAT != 0) && hb_led_d;
      S_DONE:  ack_d[gid_d] = 1'b1;
      default: led_d = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_led_blink_arbiter.sv
// Self-checking bench: timeline model of the blink arbiter plus directed scenarios.
module tb_led_blink_arbiter;
  localparam int NR = 4, CW = 4, TD = 2, ONT = 2, OFFT = 1, GAPT = 3, HB = 2, HBEN = 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  led_blink_arbiter_if #(.NUM_REQ(NR), .CODE_WIDTH(CW)) bus();

  led_blink_arbiter #(
    .NUM_REQ(NR), .CODE_WIDTH(CW), .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT), .HEARTBEAT(HBEN), .HB_TICKS(HB)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int   e_cnt = 0, t_ref = 0, m_start = 0, m_code = 0, m_gid = 0, m_rr = 0, m_hbc = 0;
  bit   m_busy = 0, m_hbl = 0;
  logic exp_led = 0, exp_busy = 0;
  logic [NR-1:0] exp_ack = '0;
  int   exp_gid = 0;

  function automatic int seq_len(input int c);
    return (c == 0) ? TD * GAPT : TD * (c * ONT + (c - 1) * OFFT + GAPT);
  endfunction

  // led level t cycles after the grant edge: pulses of ON ticks every ON+OFF ticks
  function automatic bit lit(input int c, input int t);
    return (c >= 1) && (t < TD * (c * ONT + (c - 1) * OFFT)) && (((t / TD) % (ONT + OFFT)) < ONT);
  endfunction

  task automatic model_reset();
    t_ref = e_cnt; m_busy = 0; m_gid = 0; m_rr = 0; m_hbc = 0; m_hbl = 0; m_code = 0;
    exp_led = 0; exp_busy = 0; exp_ack = '0; exp_gid = 0;
  endtask

  task automatic model_step();
    int t, p, found;
    e_cnt++;
    exp_ack = '0;
    if (m_busy) begin
      t = e_cnt - m_start;
      p = seq_len(m_code);
      if (t == p + 1) begin
        m_busy = 0; m_rr = (m_gid + 1) % NR; exp_busy = 0; exp_led = HBEN ? m_hbl : 1'b0;
      end else begin
        exp_busy = 1; exp_led = lit(m_code, t);
        if (t == p) exp_ack = NR'(1 << m_gid);
      end
    end else begin
      found = -1;
      for (int i = 0; i < NR; i++)
        if (found < 0 && bus.req[(m_rr + i) % NR]) found = (m_rr + i) % NR;
      if (found >= 0) begin
        m_busy = 1; m_start = e_cnt; m_gid = found; m_code = int'(bus.code[found*CW +: CW]);
        t_ref = e_cnt; m_hbc = 0; m_hbl = 0;
        exp_busy = 1; exp_led = lit(m_code, 0);
      end else begin
        if ((e_cnt - t_ref) % TD == 0) begin
          if (m_hbc == HB - 1) begin m_hbc = 0; m_hbl = ~m_hbl; end
          else m_hbc++;
        end
        exp_busy = 0; exp_led = HBEN ? m_hbl : 1'b0;
      end
    end
    exp_gid = m_gid;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.led !== exp_led || bus.busy !== exp_busy || bus.ack !== exp_ack ||
          int'(bus.grant_id) != exp_gid || (bus.ack != 0 && !$onehot(bus.ack))) begin
        n_fail++;
        $display("FAIL cycle@%0t: got led=%b busy=%b ack=%b gid=%0d expected led=%b busy=%b ack=%b gid=%0d",
                 $time, bus.led, bus.busy, bus.ack, bus.grant_id, exp_led, exp_busy, exp_ack, exp_gid);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; bus.req = '0; bus.code = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(posedge clk); #1;
      if (!bus.busy) idle = 1;
    end
    chk_eq({nm, "_idle"}, int'(idle), 1);
  endtask

  // Grant a single requester, swap its inputs after grant, measure ack timing/led.
  task automatic run_seq(input int id, input int cd, input int cd_alt,
                         input int x_edges, input int x_ledhi, input string nm);
    int edges, ledhi;
    bit got;
    @(negedge clk);
    bus.req = NR'(1 << id);
    bus.code[id*CW +: CW] = CW'(cd);
    @(posedge clk); #1;
    edges = 1; ledhi = bus.led ? 1 : 0;
    chk_eq({nm, "_gid"}, int'(bus.grant_id), id);
    chk_eq({nm, "_busy"}, int'(bus.busy), 1);
    @(negedge clk);
    bus.req = '0;
    bus.code[id*CW +: CW] = CW'(cd_alt);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      edges++;
      if (bus.ack != 0) got = 1;
      else if (bus.led) ledhi++;
    end
    chk_eq({nm, "_ack_seen"}, int'(got), 1);
    chk_eq({nm, "_ack_lat"}, edges, x_edges);
    chk_eq({nm, "_ack_val"}, int'(bus.ack), 1 << id);
    chk_eq({nm, "_led_hi"}, ledhi, x_ledhi);
    wait_idle(nm);
  endtask

  initial begin
    int edges, ng, grants[5];
    bit rose, fell, pb;
    bus.req = '0; bus.code = '0;

    // 1: reset values and heartbeat period
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk_eq("rst_led", int'(bus.led), 0);
    chk_eq("rst_busy", int'(bus.busy), 0);
    chk_eq("rst_ack", int'(bus.ack), 0);
    chk_eq("rst_gid", int'(bus.grant_id), 0);
    edges = 0; rose = 0; fell = 0;
    for (int i = 0; i < 20 && !fell; i++) begin
      @(posedge clk); #1;
      edges++;
      if (!rose && bus.led) begin rose = 1; chk_eq("hb_rise", edges, 4); end
      else if (rose && !bus.led) begin fell = 1; chk_eq("hb_fall", edges, 8); end
    end
    chk_eq("hb_toggled", int'(fell), 1);

    // 2: requester 2, code 3
    run_seq(2, 3, 3, 23, 12, "code3");

    // 3: all requesting, code 1 each -> rotation 0,1,2,3,0
    do_reset();
    bus.req = '1; bus.code = {NR{4'd1}};
    ng = 0; pb = 0;
    for (int i = 0; i < 300 && ng < 5; i++) begin
      @(posedge clk); #1;
      if (bus.busy && !pb) begin grants[ng] = int'(bus.grant_id); ng++; end
      pb = bus.busy;
    end
    @(negedge clk); bus.req = '0;
    chk_eq("rr_count", ng, 5);
    chk_eq("rr_g0", grants[0], 0);
    chk_eq("rr_g1", grants[1], 1);
    chk_eq("rr_g2", grants[2], 2);
    chk_eq("rr_g3", grants[3], 3);
    chk_eq("rr_g4", grants[4], 0);
    wait_idle("rr");

    // 4: code 0 -> gap only
    run_seq(1, 0, 0, 7, 0, "code0");

    // 5: reset during the second ON window, then priority restarts at 0
    do_reset();
    bus.code[3*CW +: CW] = 4'd3;
    @(negedge clk); bus.req = 4'b1000;
    @(posedge clk); #1;
    chk_eq("abort_gid", int'(bus.grant_id), 3);
    @(negedge clk); bus.req = '0;
    repeat (7) @(negedge clk);
    chk_eq("abort_mid_on", int'(bus.led), 1);
    resetn = 1'b0;
    #1;
    chk_eq("abort_led", int'(bus.led), 0);
    chk_eq("abort_busy", int'(bus.busy), 0);
    chk_eq("abort_ack", int'(bus.ack), 0);
    repeat (2) @(negedge clk);
    bus.req = 4'b0110; bus.code = {NR{4'd1}};
    resetn = 1'b1;
    @(posedge clk); #1;
    chk_eq("post_rst_gid", int'(bus.grant_id), 1);
    chk_eq("post_rst_busy", int'(bus.busy), 1);
    @(negedge clk); bus.req = '0;
    wait_idle("post_rst");

    // 6: requester 3 drops req and changes code after grant; latched code 2 plays
    run_seq(3, 2, 7, 17, 8, "latched");

    repeat (10) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
